fb_column_writer: RTL and testbench



---
 rtl/fb_column_writer_if.sv | 27 ++
 rtl/fb_column_writer.sv | 127 ++++++++++++
 tb/tb_fb_column_writer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_column_writer_if.sv
// rtl/fb_column_writer_if.sv - column descriptor and frame buffer write port bundle for fb_column_writer
interface fb_column_writer_if;
    logic        col_valid_in;
    logic        col_ready_out;
    logic [8:0]  col_x_in;
    logic [7:0]  col_height_in;
    logic [7:0]  col_color_in;
    logic        col_side_in;
    logic        col_last_in;
    logic [1:0]  fb_ready_to_switch_in;
    logic [15:0] ray_address_out;
    logic [8:0]  ray_pixel_out;
    logic        ray_valid_out;
    logic        ray_last_pixel_out;

    modport slave (
        input  col_valid_in, col_x_in, col_height_in, col_color_in, col_side_in, col_last_in,
        input  fb_ready_to_switch_in,
        output col_ready_out, ray_address_out, ray_pixel_out, ray_valid_out, ray_last_pixel_out
    );

    modport master (
        output col_valid_in, col_x_in, col_height_in, col_color_in, col_side_in, col_last_in,
        output fb_ready_to_switch_in,
        input  col_ready_out, ray_address_out, ray_pixel_out, ray_valid_out, ray_last_pixel_out
    );
endinterface

// File: rtl/fb_column_writer.sv
// rtl/fb_column_writer.sv - expands raycast column descriptors into frame buffer pixel writes
// Optional macro FB_COLUMN_WRITER_SIDE_SHADE_EN: wall pixels carry the latched side bit as shade.
module fb_column_writer #(
    parameter int         SCREEN_WIDTH  = 320,
    parameter int         SCREEN_HEIGHT = 180,
    parameter logic [7:0] CEIL_COLOR    = 8'h01,
    parameter logic [7:0] FLOOR_COLOR   = 8'h02
) (
    input logic              pixel_clk_in,
    input logic              rst_n_in,
    fb_column_writer_if.slave bus
);
    localparam logic [15:0] WIDTH16 = 16'(SCREEN_WIDTH);
    localparam logic [8:0]  WIDTH9  = 9'(SCREEN_WIDTH);
    localparam logic [7:0]  HEIGHT8 = 8'(SCREEN_HEIGHT);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

    state_t      state;
    logic [7:0]  y;
    logic [7:0]  top_q;
    logic [7:0]  bottom_q;
    logic [7:0]  color_q;
    logic        side_q;
    logic        last_q;
    logic        skip_q;
    logic        swap_seen;
    logic [15:0] addr_cnt;

    logic [7:0]  h_clip;
    logic [7:0]  top_next;
    logic [7:0]  bottom_next;
    logic        wall_shade;
    logic [8:0]  pixel_next;

    assign bus.col_ready_out = (state == IDLE);

    // h=0 yields bottom = top-1, so the wall test below never matches.
    always_comb begin
        h_clip      = (bus.col_height_in > HEIGHT8) ? HEIGHT8 : bus.col_height_in;
        top_next    = (HEIGHT8 - h_clip) >> 1;
        bottom_next = top_next + h_clip - 8'd1;
    end

`ifdef FB_COLUMN_WRITER_SIDE_SHADE_EN
    assign wall_shade = side_q;
    logic unused_bits;
    assign unused_bits = bus.fb_ready_to_switch_in[1];
`else
    assign wall_shade = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.fb_ready_to_switch_in[1], side_q};
`endif

    always_comb begin
        pixel_next = {1'b0, FLOOR_COLOR};
        if (y < top_q) begin
            pixel_next = {1'b0, CEIL_COLOR};
        end else if (y <= bottom_q) begin
            pixel_next = {wall_shade, color_q};
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state                  <= IDLE;
            y                      <= 8'd0;
            top_q                  <= 8'd0;
            bottom_q               <= 8'd0;
            color_q                <= 8'd0;
            side_q                 <= 1'b0;
            last_q                 <= 1'b0;
            skip_q                 <= 1'b0;
            swap_seen              <= 1'b0;
            addr_cnt               <= 16'd0;
            bus.ray_address_out    <= 16'd0;
            bus.ray_pixel_out      <= 9'd0;
            bus.ray_valid_out      <= 1'b0;
            bus.ray_last_pixel_out <= 1'b0;
        end else begin
            bus.ray_valid_out      <= 1'b0;
            bus.ray_last_pixel_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.col_valid_in) begin
                        top_q     <= top_next;
                        bottom_q  <= bottom_next;
                        color_q   <= bus.col_color_in;
                        side_q    <= bus.col_side_in;
                        last_q    <= bus.col_last_in;
                        skip_q    <= (bus.col_x_in >= WIDTH9);
                        swap_seen <= 1'b0;
                        y         <= 8'd0;
                        addr_cnt  <= {7'd0, bus.col_x_in};
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (skip_q) begin
                        // Off-screen column: no pixels, but the frame-end marker still goes out.
                        bus.ray_last_pixel_out <= last_q;
                        state                  <= last_q ? WAIT_SWAP : IDLE;
                    end else begin
                        bus.ray_address_out <= addr_cnt;
                        bus.ray_pixel_out   <= pixel_next;
                        bus.ray_valid_out   <= 1'b1;
                        addr_cnt            <= addr_cnt + WIDTH16;
                        y                   <= y + 8'd1;
                        if (y == HEIGHT8 - 8'd1) begin
                            bus.ray_last_pixel_out <= last_q;
                            state                  <= last_q ? WAIT_SWAP : IDLE;
                        end
                    end
                end
                WAIT_SWAP: begin
                    // Swap completes on the falling edge of bit0 after it has been seen high.
                    if (bus.fb_ready_to_switch_in[0]) begin
                        swap_seen <= 1'b1;
                    end else if (swap_seen) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_column_writer.sv
// tb/tb_fb_column_writer.sv - directed self-checking bench for fb_column_writer
module tb_fb_column_writer;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

`ifdef FB_COLUMN_WRITER_SIDE_SHADE_EN
    localparam logic SHADE_ON = 1'b1;
`else
    localparam logic SHADE_ON = 1'b0;
`endif

    fb_column_writer_if bus ();

    fb_column_writer dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [8:0] exp_pixel(int yy, int h, logic [7:0] c, logic s);
        int hh;
        int top;
        hh  = (h > 180) ? 180 : h;
        top = (180 - hh) / 2;
        if (yy < top) return 9'h001;
        if (yy < top + hh) return {s & SHADE_ON, c};
        return 9'h002;
    endfunction

    task automatic accept(input int x, input int h, input logic [7:0] c, input logic s, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.col_ready_out !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL accept_ready got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
        bus.col_x_in      = 9'(x);
        bus.col_height_in = 8'(h);
        bus.col_color_in  = c;
        bus.col_side_in   = s;
        bus.col_last_in   = l;
        bus.col_valid_in  = 1'b1;
        @(posedge clk);
        #1;
        bus.col_valid_in  = 1'b0;
    endtask

    task automatic check_column(input int x, input int h, input logic [7:0] c, input logic s, input logic l);
        logic [15:0] ea;
        logic [8:0]  ep;
        for (int yy = 0; yy < 180; yy++) begin
            tick();
            ea = 16'(x + 320 * yy);
            ep = exp_pixel(yy, h, c, s);
            total_cnt++;
            if (bus.ray_valid_out !== 1'b1) $display("FAIL col_valid h=%0d y=%0d got=%b want=1", h, yy, bus.ray_valid_out);
            else pass_cnt++;
            total_cnt++;
            if (bus.ray_address_out !== ea) $display("FAIL col_addr h=%0d y=%0d got=%0d want=%0d", h, yy, bus.ray_address_out, ea);
            else pass_cnt++;
            total_cnt++;
            if (bus.ray_pixel_out !== ep) $display("FAIL col_pixel h=%0d y=%0d got=%h want=%h", h, yy, bus.ray_pixel_out, ep);
            else pass_cnt++;
            total_cnt++;
            if (bus.ray_last_pixel_out !== (l && yy == 179)) $display("FAIL col_last h=%0d y=%0d got=%b want=%b", h, yy, bus.ray_last_pixel_out, (l && yy == 179));
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.col_ready_out !== !l) $display("FAIL col_ready_end h=%0d got=%b want=%b", h, bus.col_ready_out, !l);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.col_valid_in = 1'b0;
        bus.col_x_in = '0;
        bus.col_height_in = '0;
        bus.col_color_in = '0;
        bus.col_side_in = 1'b0;
        bus.col_last_in = 1'b0;
        bus.fb_ready_to_switch_in = 2'b00;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.ray_address_out, bus.ray_pixel_out, bus.ray_valid_out, bus.ray_last_pixel_out} !== 27'd0)
            $display("FAIL reset_outputs got=%h/%h/%b/%b want=0", bus.ray_address_out, bus.ray_pixel_out, bus.ray_valid_out, bus.ray_last_pixel_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL reset_ready got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic_column();
        logic [8:0] ep;
        accept(5, 80, 8'h33, 1'b1, 1'b0);
        for (int yy = 0; yy < 180; yy++) begin
            tick();
            if (yy < 50) ep = 9'h001;
            else if (yy < 130) ep = {SHADE_ON, 8'h33};
            else ep = 9'h002;
            total_cnt++;
            if (bus.ray_valid_out !== 1'b1 || bus.ray_address_out !== 16'(5 + 320 * yy))
                $display("FAIL basic_addr y=%0d got=%0d/%b want=%0d/1", yy, bus.ray_address_out, bus.ray_valid_out, 5 + 320 * yy);
            else pass_cnt++;
            total_cnt++;
            if (bus.ray_pixel_out !== ep) $display("FAIL basic_pixel y=%0d got=%h want=%h", yy, bus.ray_pixel_out, ep);
            else pass_cnt++;
            total_cnt++;
            if (bus.ray_last_pixel_out !== 1'b0) $display("FAIL basic_no_last y=%0d got=%b want=0", yy, bus.ray_last_pixel_out);
            else pass_cnt++;
            if (yy == 0) begin
                total_cnt++;
                if (bus.col_ready_out !== 1'b0) $display("FAIL basic_busy got=%b want=0", bus.col_ready_out);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL basic_ready_181 got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
    endtask

    task automatic test_heights();
        accept(7, 0, 8'h44, 1'b1, 1'b0);
        check_column(7, 0, 8'h44, 1'b1, 1'b0);
        accept(8, 255, 8'h55, 1'b1, 1'b0);
        check_column(8, 255, 8'h55, 1'b1, 1'b0);
        accept(9, 1, 8'h66, 1'b1, 1'b0);
        check_column(9, 1, 8'h66, 1'b1, 1'b0);
    endtask

    task automatic test_last_column();
        accept(319, 80, 8'h77, 1'b0, 1'b1);
        check_column(319, 80, 8'h77, 1'b0, 1'b1);
        tick();
        total_cnt++;
        if (bus.ray_last_pixel_out !== 1'b0 || bus.ray_valid_out !== 1'b0)
            $display("FAIL last_single_pulse got=%b/%b want=0/0", bus.ray_last_pixel_out, bus.ray_valid_out);
        else pass_cnt++;
        bus.fb_ready_to_switch_in = 2'b00;
        repeat (3) tick();
        total_cnt++;
        if (bus.ray_address_out !== 16'd57599 || bus.ray_pixel_out !== 9'h002)
            $display("FAIL last_hold got=%0d/%h want=57599/002", bus.ray_address_out, bus.ray_pixel_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.col_ready_out !== 1'b0) $display("FAIL last_wait_00 got=%b want=0", bus.col_ready_out);
        else pass_cnt++;
        bus.fb_ready_to_switch_in = 2'b01;
        tick();
        total_cnt++;
        if (bus.col_ready_out !== 1'b0) $display("FAIL last_wait_01 got=%b want=0", bus.col_ready_out);
        else pass_cnt++;
        bus.fb_ready_to_switch_in = 2'b11;
        tick();
        total_cnt++;
        if (bus.col_ready_out !== 1'b0) $display("FAIL last_wait_11 got=%b want=0", bus.col_ready_out);
        else pass_cnt++;
        bus.fb_ready_to_switch_in = 2'b00;
        tick();
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL last_swap_done got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
    endtask

    task automatic test_invalid_x();
        int nvalid;
        int nlast;
        accept(320, 80, 8'h88, 1'b0, 1'b1);
        tick();
        total_cnt++;
        if (bus.ray_last_pixel_out !== 1'b1 || bus.ray_valid_out !== 1'b0)
            $display("FAIL inv_last_pulse got=%b/%b want=1/0", bus.ray_last_pixel_out, bus.ray_valid_out);
        else pass_cnt++;
        nvalid = 0;
        nlast  = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.ray_valid_out === 1'b1) nvalid++;
            if (bus.ray_last_pixel_out === 1'b1) nlast++;
        end
        total_cnt++;
        if (nvalid !== 0 || nlast !== 0) $display("FAIL inv_no_pixels got=%0d/%0d want=0/0", nvalid, nlast);
        else pass_cnt++;
        total_cnt++;
        if (bus.col_ready_out !== 1'b0) $display("FAIL inv_wait_swap got=%b want=0", bus.col_ready_out);
        else pass_cnt++;
        bus.fb_ready_to_switch_in = 2'b01;
        tick();
        bus.fb_ready_to_switch_in = 2'b00;
        tick();
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL inv_swap_done got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_column();
        int nvalid;
        accept(10, 80, 8'h44, 1'b0, 1'b0);
        for (int yy = 0; yy <= 40; yy++) tick();
        total_cnt++;
        if (bus.ray_address_out !== 16'(10 + 320 * 40)) $display("FAIL rst_mid_pos got=%0d want=%0d", bus.ray_address_out, 10 + 320 * 40);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.ray_address_out, bus.ray_pixel_out, bus.ray_valid_out, bus.ray_last_pixel_out} !== 27'd0)
            $display("FAIL rst_mid_async got=%h/%h/%b/%b want=0", bus.ray_address_out, bus.ray_pixel_out, bus.ray_valid_out, bus.ray_last_pixel_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.ray_valid_out === 1'b1) nvalid++;
        end
        total_cnt++;
        if (nvalid !== 0) $display("FAIL rst_mid_residual got=%0d want=0", nvalid);
        else pass_cnt++;
        total_cnt++;
        if (bus.col_ready_out !== 1'b1) $display("FAIL rst_mid_ready got=%b want=1", bus.col_ready_out);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic_column();
        test_heights();
        test_last_column();
        test_invalid_x();
        test_reset_mid_column();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
